// File: rtl/bias_fetch.sv
// Bias ROM read sequencer: streams NUM_CH signed biases through a small FIFO to the bias-add stage.
// Optional round-half-up before the shift when BIAS_FETCH_ROUND_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; cena held high
// RUN   | issuing ROM reads as FIFO credit allows
// DRAIN | all reads issued; waiting for the FIFO to empty, then done
module bias_fetch #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              cena,
  output logic [ADDR_W-1:0] aa,
  input  logic [DATA_W-1:0] qa,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] b_idx
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rp, rp_nxt;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue, done_nxt, credit_ok;

  logic              rd_v;
  logic [ADDR_W-1:0] rd_idx;
  logic [1:0]        inflight;

  logic [CW-1:0]     count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] mem_i [DEPTH];
  logic              push, pop;
  logic [DATA_W-1:0] shaped;

`ifdef BIAS_FETCH_ROUND_EN
  // One extra bit of headroom so the largest positive word cannot wrap on the add.
  localparam logic [DATA_W:0] RND = (DATA_W+1)'((1 << SHIFT) >> 1);
  logic signed [DATA_W:0] rnd_sum, rnd_shf;
  assign rnd_sum = $signed({qa[DATA_W-1], qa}) + $signed(RND);
  assign rnd_shf = rnd_sum >>> SHIFT;
  assign shaped  = DATA_W'(rnd_shf);
`else
  assign shaped = $signed(qa) >>> SHIFT;
`endif

  assign inflight = {1'b0, ~cena} + {1'b0, rd_v};
  assign push     = rd_v;
  assign b_valid  = (count != '0);
  assign pop      = b_valid && b_ready;
  assign b_data   = mem_d[rd_ptr];
  assign b_idx    = mem_i[rd_ptr];
  assign busy     = (state != S_IDLE);

  // A pop on this edge frees a slot, so it counts toward the credit for a new read.
  assign credit_ok = (32'(count) + 32'(inflight)) < (32'(DEPTH) + (pop ? 32'd1 : 32'd0));

  always_comb begin
    state_nxt  = state;
    rp_nxt     = rp;
    issue      = 1'b0;
    issue_addr = rp;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        // start coinciding with done belongs to the finished run
        if (start && !done) begin
          issue      = 1'b1;
          issue_addr = '0;
          if (LAST == '0) begin
            state_nxt = S_DRAIN;
            rp_nxt    = '0;
          end else begin
            state_nxt = S_RUN;
            rp_nxt    = ADDR_W'(1);
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (rp == LAST) state_nxt = S_DRAIN;
          else            rp_nxt    = rp + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (count == '0 && inflight == 2'd0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      rp     <= '0;
      cena   <= 1'b1;
      aa     <= '0;
      rd_v   <= 1'b0;
      rd_idx <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rp     <= rp_nxt;
      cena   <= ~issue;
      if (issue) aa <= issue_addr;
      rd_v   <= ~cena;
      rd_idx <= aa;
      done   <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_i[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= shaped;
        mem_i[wr_ptr] <= rd_idx;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_fetch.sv
// Directed testbench for bias_fetch: stream order, backpressure, restart filtering, reset, shift/round.
module tb_bias_fetch;
  logic        clk = 1'b0;
  logic        rstn, start, b_ready;
  logic        busy, done, cena, b_valid;
  logic [2:0]  aa, b_idx;
  logic [23:0] qa = '0, b_data;

  logic        start8, b_ready8;
  logic        busy8, done8, cena8, b_valid8;
  logic [2:0]  aa8, b_idx8;
  logic [23:0] qa8 = '0, b_data8;

  int errors = 0;
  int checks = 0;
  int rom_v [6] = '{-33091, -345382, -986031, -314271, 400309, -448129};

  always #5 clk = ~clk;

  bias_fetch dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .cena(cena), .aa(aa),
    .qa(qa), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_idx(b_idx)
  );

  bias_fetch #(.SHIFT(8)) dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .busy(busy8), .done(done8), .cena(cena8), .aa(aa8),
    .qa(qa8), .b_valid(b_valid8), .b_ready(b_ready8), .b_data(b_data8), .b_idx(b_idx8)
  );

  // Registered-read ROM models
  always @(posedge clk) if (!cena)  qa  <= 24'(rom_v[aa]);
  always @(posedge clk) if (!cena8) qa8 <= 24'(rom_v[aa8]);

  always @(negedge clk) begin
    if (rstn && dut.count > 4) begin
      errors++;
      $display("FAIL fifo_overflow count=%0d limit=4", dut.count);
    end
  end

  int          got_n, done_cnt, first_valid, cena_low, cena_run, cena_maxrun;
  int          aa_bad, hold_bad, busy_bad, timed_out, hold_low;
  logic        hold_cena, hold_valid;
  logic [23:0] hold_d;
  logic [2:0]  hold_i;
  logic [23:0] got_d [16];
  logic [2:0]  got_i [16];

  // Runs one transfer sequence from the current negedge and records what the DUT did.
  // mode 0: ready high, 1: random ready, 2: ready low until hold_cyc then high.
  task automatic collect(input int mode, input int hold_cyc, input int rs1, input int rs2,
                         input bit start_on_done);
    int cyc = 0, after = -1, exp_aa = 0;
    bit pv = 0, pr = 1, pbusy = 0, seen_done = 0;
    logic [23:0] pd = '0;
    logic [2:0]  pi = '0;
    got_n = 0; done_cnt = 0; first_valid = -1; cena_low = 0; cena_run = 0; cena_maxrun = 0;
    aa_bad = 0; hold_bad = 0; busy_bad = 0; timed_out = 0; hold_low = -1;
    hold_cena = 0; hold_valid = 0; hold_d = '0; hold_i = '0;
    b_ready = (mode == 2) ? 1'b0 : 1'b1;
    start = 1'b1;
    while (cyc < 200 && after != 0) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == rs1 || cyc == rs2);
      if (after > 0) after--;
      if (!cena) begin
        cena_low++; cena_run++;
        if (aa !== 3'(exp_aa)) aa_bad++;
        exp_aa++;
        if (cena_run > cena_maxrun) cena_maxrun = cena_run;
      end else cena_run = 0;
      if (b_valid && first_valid < 0) first_valid = cyc;
      if (pv && !pr && (!b_valid || b_data !== pd || b_idx !== pi)) hold_bad++;
      if (seen_done && busy) busy_bad++;
      if (done) begin
        done_cnt++;
        if (busy || !pbusy) busy_bad++;
        if (start_on_done) start = 1'b1;
        if (after < 0) after = 6;
        seen_done = 1;
      end
      if (cyc == hold_cyc) begin
        hold_low = cena_low; hold_cena = cena; hold_valid = b_valid; hold_d = b_data; hold_i = b_idx;
      end
      case (mode)
        1:       b_ready = 1'($urandom_range(0, 1));
        2:       b_ready = (cyc >= hold_cyc);
        default: b_ready = 1'b1;
      endcase
      if (b_valid && b_ready) begin
        if (got_n < 16) begin got_d[got_n] = b_data; got_i[got_n] = b_idx; end
        got_n++;
      end
      pv = b_valid; pr = b_ready; pd = b_data; pi = b_idx; pbusy = busy;
    end
    start = 1'b0;
    b_ready = 1'b1;
    if (after != 0) timed_out = 1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; b_ready = 1'b1; start8 = 1'b0; b_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cena !== 1'b1)    begin errors++; $display("FAIL reset_cena got=%b exp=1", cena); end
    checks++; if (aa !== 3'd0)      begin errors++; $display("FAIL reset_aa got=%0d exp=0", aa); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", b_valid); end
    checks++; if (b_data !== 24'd0 || b_idx !== 3'd0)
      begin errors++; $display("FAIL reset_head got=%h/%0d exp=0/0", b_data, b_idx); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stream(input string nm, input int mode);
    collect(mode, 0, 0, 0, 0);
    checks++; if (timed_out != 0) begin errors++; $display("FAIL %s_timeout got=%0d exp=0", nm, timed_out); end
    checks++; if (got_n != 6) begin errors++; $display("FAIL %s_count got=%0d exp=6", nm, got_n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_d[i] !== 24'(rom_v[i]) || got_i[i] !== 3'(i)) begin
        errors++;
        $display("FAIL %s_item%0d got=%0d/%0d exp=%0d/%0d", nm, i, $signed(got_d[i]), got_i[i], rom_v[i], i);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done got=%0d exp=1", nm, done_cnt); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s_busy got=%0d exp=0", nm, busy_bad); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL %s_stable got=%0d exp=0", nm, hold_bad); end
    checks++; if (aa_bad != 0 || cena_low != 6)
      begin errors++; $display("FAIL %s_reads got=%0d/%0d exp=0/6", nm, aa_bad, cena_low); end
    if (mode == 0) begin
      checks++; if (first_valid != 3) begin errors++; $display("FAIL stream_latency got=%0d exp=3", first_valid); end
      checks++; if (cena_maxrun != 6) begin errors++; $display("FAIL stream_cena_run got=%0d exp=6", cena_maxrun); end
    end
  endtask

  task automatic test_backpressure();
    collect(2, 20, 0, 0, 0);
    checks++; if (hold_low != 4) begin errors++; $display("FAIL bp_reads got=%0d exp=4", hold_low); end
    checks++; if (hold_cena !== 1'b1 || hold_valid !== 1'b1)
      begin errors++; $display("FAIL bp_state got=%b/%b exp=1/1", hold_cena, hold_valid); end
    checks++; if (hold_d !== 24'(rom_v[0]) || hold_i !== 3'd0)
      begin errors++; $display("FAIL bp_head got=%0d/%0d exp=%0d/0", $signed(hold_d), hold_i, rom_v[0]); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", hold_bad); end
    checks++; if (got_n != 6 || done_cnt != 1 || timed_out != 0)
      begin errors++; $display("FAIL bp_finish got=%0d/%0d/%0d exp=6/1/0", got_n, done_cnt, timed_out); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_d[i] !== 24'(rom_v[i]) || got_i[i] !== 3'(i)) begin
        errors++;
        $display("FAIL bp_item%0d got=%0d/%0d exp=%0d/%0d", i, $signed(got_d[i]), got_i[i], rom_v[i], i);
      end
    end
  endtask

  task automatic test_restart();
    // extra starts sampled in RUN (edge 3), DRAIN (edge 8) and on the done cycle
    collect(0, 0, 2, 7, 1);
    checks++; if (got_n != 6 || done_cnt != 1 || cena_low != 6)
      begin errors++; $display("FAIL restart_ignored got=%0d/%0d/%0d exp=6/1/6", got_n, done_cnt, cena_low); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL restart_busy got=%0d exp=0", busy_bad); end
    test_stream("rerun", 0);
  endtask

  task automatic test_reset_midrun();
    int n = 0, cyc = 0, bad = 0;
    b_ready = 1'b1;
    start = 1'b1;
    while (n < 3 && cyc < 30) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      start = 1'b0;
      if (b_valid) n++;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL midrun_reach got=%0d exp=3", n); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (cena !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || b_valid !== 1'b0)
      begin errors++; $display("FAIL midrun_ctrl got=%b%b%b%b exp=1000", cena, busy, done, b_valid); end
    checks++; if (aa !== 3'd0 || b_data !== 24'd0 || b_idx !== 3'd0)
      begin errors++; $display("FAIL midrun_data got=%0d/%h/%0d exp=0/0/0", aa, b_data, b_idx); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (b_valid || done || busy || !cena) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrun_quiet got=%0d exp=0", bad); end
    test_stream("after_rst", 0);
  endtask

  task automatic test_shift();
    int n = 0;
    int g [8];
    int exp0, exp4;
`ifdef BIAS_FETCH_ROUND_EN
    exp0 = -129; exp4 = 1564;
`else
    exp0 = -130; exp4 = 1563;
`endif
    b_ready8 = 1'b1;
    start8 = 1'b1;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      if (b_valid8 && n < 8) begin g[n] = $signed(b_data8); n++; end
    end
    checks++; if (n != 6) begin errors++; $display("FAIL shift_count got=%0d exp=6", n); end
    checks++; if (g[0] != exp0) begin errors++; $display("FAIL shift_neg got=%0d exp=%0d", g[0], exp0); end
    checks++; if (g[4] != exp4) begin errors++; $display("FAIL shift_pos got=%0d exp=%0d", g[4], exp4); end
  endtask

  initial begin
    test_reset();
    test_stream("stream", 0);
    test_backpressure();
    test_stream("random", 1);
    test_restart();
    test_reset_midrun();
    test_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
